// File: rtl/alu_decoder_pkg.sv
// Shared definitions for the SM83 ALU front end: operand register indices,
// ALU op encodings, decoder FSM states and the ALU command field bundle.
package alu_decoder_pkg;

    // Prefix byte that selects the extension opcode page
    localparam logic [7:0] CB_PREFIX = 8'hCB;

    // Register indices as they appear in the opcode operand fields
    localparam logic [2:0] IDX_A  = 3'd7;
    localparam logic [2:0] IDX_HL = 3'd6;

    // Base page ALU ops (opcode bits [5:3])
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_ADC = 3'd1;
    localparam logic [2:0] ALU_SUB = 3'd2;
    localparam logic [2:0] ALU_SBC = 3'd3;
    localparam logic [2:0] ALU_AND = 3'd4;
    localparam logic [2:0] ALU_XOR = 3'd5;
    localparam logic [2:0] ALU_OR  = 3'd6;
    localparam logic [2:0] ALU_CP  = 3'd7;

    // CB page rotate/shift ops (second byte bits [5:3] when bits [7:6] are 00)
    localparam logic [2:0] ALU_RLC  = 3'd0;
    localparam logic [2:0] ALU_RRC  = 3'd1;
    localparam logic [2:0] ALU_RL   = 3'd2;
    localparam logic [2:0] ALU_RR   = 3'd3;
    localparam logic [2:0] ALU_SLA  = 3'd4;
    localparam logic [2:0] ALU_SRA  = 3'd5;
    localparam logic [2:0] ALU_SWAP = 3'd6;
    localparam logic [2:0] ALU_SRL  = 3'd7;

    // Base page misc group (misc=1, ext=0)
    localparam logic [2:0] ALU_DAA = 3'd0;
    localparam logic [2:0] ALU_CPL = 3'd1;
    localparam logic [2:0] ALU_SCF = 3'd2;
    localparam logic [2:0] ALU_CCF = 3'd3;

    // CB page bit ops (misc=1, ext=1); op is {1'b0, b[7:6]}
    localparam logic [2:0] ALU_BIT = 3'd1;
    localparam logic [2:0] ALU_RES = 3'd2;
    localparam logic [2:0] ALU_SET = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CB    = 2'd1,
        ST_IMM   = 2'd2,
        ST_ISSUE = 2'd3
    } dec_state_e;

    // What the FSM should do with a decoded byte
    typedef enum logic [1:0] {
        DK_NONALU = 2'd0,
        DK_ISSUE  = 2'd1,
        DK_IMM    = 2'd2,
        DK_PREFIX = 2'd3
    } dec_kind_e;

    typedef struct packed {
        logic [2:0] op;
        logic [2:0] src;
        logic [2:0] dest;
        logic       size;
        logic       ext;
        logic       misc;
        logic       imm;
        logic       mem_rd;
        logic       mem_wr;
        logic [2:0] mcycles;
    } alu_fields_t;

    // CB page M-cycle count: register form 2, (HL) BIT 3, other (HL) forms 4
    function automatic logic [2:0] cb_mcycles(input logic mem_rd, input logic is_bit);
        if (!mem_rd) begin
            return 3'd2;
        end else if (is_bit) begin
            return 3'd3;
        end else begin
            return 3'd4;
        end
    endfunction

endpackage

// File: rtl/alu_decode_comb.sv
// Purely combinational byte decoder: opcode byte plus page select in,
// ALU field bundle and FSM action out.
module alu_decode_comb
    import alu_decoder_pkg::*;
(
    input  logic [7:0]  byte_in,
    input  logic        page_cb,
    output alu_fields_t fields,
    output dec_kind_e   kind
);

    logic is_misc_cb;
    logic is_bit_cb;

    assign is_misc_cb = (byte_in[7:6] != 2'b00);
    assign is_bit_cb  = (byte_in[7:6] == ALU_BIT[1:0]);

    // Map the byte to ALU fields for whichever page is active
    always_comb begin
        fields = '0;
        kind   = DK_NONALU;
        if (page_cb) begin
            // Every CB second byte is an ALU op; the operand field is also the destination
            kind          = DK_ISSUE;
            fields.ext    = 1'b1;
            fields.dest   = byte_in[2:0];
            fields.misc   = is_misc_cb;
            fields.op     = is_misc_cb ? {1'b0, byte_in[7:6]} : byte_in[5:3];
            fields.src    = is_misc_cb ? byte_in[5:3] : byte_in[2:0];
            fields.mem_rd = (byte_in[2:0] == IDX_HL);
            // BIT only reads (HL); everything else on (HL) writes the result back
            fields.mem_wr  = fields.mem_rd && !is_bit_cb;
            fields.mcycles = cb_mcycles(fields.mem_rd, is_bit_cb);
        end else if (byte_in[7:6] == 2'b10) begin
            // Register/(HL) operand into A
            kind           = DK_ISSUE;
            fields.op      = byte_in[5:3];
            fields.src     = byte_in[2:0];
            fields.dest    = IDX_A;
            fields.mem_rd  = (byte_in[2:0] == IDX_HL);
            fields.mcycles = fields.mem_rd ? 3'd2 : 3'd1;
        end else if (byte_in[7:6] == 2'b11 && byte_in[2:0] == 3'b110) begin
            // d8 immediate into A; immediate follows in the next byte
            kind           = DK_IMM;
            fields.op      = byte_in[5:3];
            fields.src     = 3'd0;
            fields.dest    = IDX_A;
            fields.imm     = 1'b1;
            fields.mcycles = 3'd2;
        end else if (byte_in[7:5] == 3'b001 && byte_in[2:0] == 3'b111) begin
            // DAA / CPL / SCF / CCF act on A in place
            kind           = DK_ISSUE;
            fields.op      = {1'b0, byte_in[4:3]};
            fields.src     = IDX_A;
            fields.dest    = IDX_A;
            fields.misc    = 1'b1;
            fields.mcycles = 3'd1;
        end else if (byte_in == CB_PREFIX) begin
            kind = DK_PREFIX;
        end
    end

endmodule

// File: rtl/alu_decoder.sv
// SM83 ALU front end: accepts opcode/CB/d8 bytes over valid/ready, issues one
// registered ALU command per instruction and flags non-ALU opcodes.
module alu_decoder
    import alu_decoder_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       op_valid,
    input  logic [7:0] op_byte,
    output logic       op_ready,
    output logic       alu_valid,
    input  logic       alu_ready,
    output logic [2:0] alu_op,
    output logic [2:0] alu_src,
    output logic [2:0] alu_dest,
    output logic       alu_size,
    output logic       alu_ext,
    output logic       alu_misc,
    output logic       alu_imm,
    output logic [7:0] alu_imm_data,
    output logic       alu_mem_rd,
    output logic       alu_mem_wr,
    output logic [2:0] alu_mcycles,
    output logic       nonalu_valid,
    output logic [7:0] nonalu_byte
);

    dec_state_e  state_q, state_d;
    alu_fields_t fields_q, fields_d;
    logic [7:0]  imm_data_q, imm_data_d;
    logic        alu_valid_q, alu_valid_d;
    logic        op_ready_q, op_ready_d;
    logic        nonalu_valid_q, nonalu_valid_d;
    logic [7:0]  nonalu_byte_q, nonalu_byte_d;

    alu_fields_t dec_fields;
    dec_kind_e   dec_kind;
    logic        accept;

    alu_decode_comb u_decode (
        .byte_in (op_byte),
        .page_cb (state_q == ST_CB),
        .fields  (dec_fields),
        .kind    (dec_kind)
    );

    assign accept = op_valid && op_ready_q && !flush;

    // Next-state and next-output logic; fields only change when a byte is accepted
    always_comb begin
        state_d        = state_q;
        fields_d       = fields_q;
        imm_data_d     = imm_data_q;
        nonalu_valid_d = 1'b0;
        nonalu_byte_d  = nonalu_byte_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        unique case (dec_kind)
                            DK_ISSUE: begin
                                fields_d = dec_fields;
                                state_d  = ST_ISSUE;
                            end
                            DK_IMM: begin
                                fields_d = dec_fields;
                                state_d  = ST_IMM;
                            end
                            DK_PREFIX: begin
                                state_d = ST_CB;
                            end
                            default: begin
                                nonalu_valid_d = 1'b1;
                                nonalu_byte_d  = op_byte;
                            end
                        endcase
                    end
                end
                ST_CB: begin
                    if (accept) begin
                        fields_d = dec_fields;
                        state_d  = ST_ISSUE;
                    end
                end
                ST_IMM: begin
                    if (accept) begin
                        imm_data_d = op_byte;
                        state_d    = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (alu_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        alu_valid_d = (state_d == ST_ISSUE);
        op_ready_d  = (state_d != ST_ISSUE);
    end

    // State and output registers; reset discards any partial instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            fields_q       <= '0;
            imm_data_q     <= 8'd0;
            alu_valid_q    <= 1'b0;
            op_ready_q     <= 1'b1;
            nonalu_valid_q <= 1'b0;
            nonalu_byte_q  <= 8'd0;
        end else begin
            state_q        <= state_d;
            fields_q       <= fields_d;
            imm_data_q     <= imm_data_d;
            alu_valid_q    <= alu_valid_d;
            op_ready_q     <= op_ready_d;
            nonalu_valid_q <= nonalu_valid_d;
            nonalu_byte_q  <= nonalu_byte_d;
        end
    end

    assign op_ready     = op_ready_q;
    assign alu_valid    = alu_valid_q;
    assign alu_op       = fields_q.op;
    assign alu_src      = fields_q.src;
    assign alu_dest     = fields_q.dest;
    assign alu_size     = fields_q.size;
    assign alu_ext      = fields_q.ext;
    assign alu_misc     = fields_q.misc;
    assign alu_imm      = fields_q.imm;
    assign alu_imm_data = imm_data_q;
    assign alu_mem_rd   = fields_q.mem_rd;
    assign alu_mem_wr   = fields_q.mem_wr;
    assign alu_mcycles  = fields_q.mcycles;
    assign nonalu_valid = nonalu_valid_q;
    assign nonalu_byte  = nonalu_byte_q;

endmodule

// File: tb/tb_alu_decoder.sv
// Directed bench for alu_decoder: hand-decoded opcode vectors, stall, flush and reset.
module tb_alu_decoder;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       op_valid;
    logic [7:0] op_byte;
    logic       op_ready;
    logic       alu_valid;
    logic       alu_ready;
    logic [2:0] alu_op;
    logic [2:0] alu_src;
    logic [2:0] alu_dest;
    logic       alu_size;
    logic       alu_ext;
    logic       alu_misc;
    logic       alu_imm;
    logic [7:0] alu_imm_data;
    logic       alu_mem_rd;
    logic       alu_mem_wr;
    logic [2:0] alu_mcycles;
    logic       nonalu_valid;
    logic [7:0] nonalu_byte;

    int n_checks = 0;
    int n_errors = 0;

    alu_decoder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .op_valid     (op_valid),
        .op_byte      (op_byte),
        .op_ready     (op_ready),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_op       (alu_op),
        .alu_src      (alu_src),
        .alu_dest     (alu_dest),
        .alu_size     (alu_size),
        .alu_ext      (alu_ext),
        .alu_misc     (alu_misc),
        .alu_imm      (alu_imm),
        .alu_imm_data (alu_imm_data),
        .alu_mem_rd   (alu_mem_rd),
        .alu_mem_wr   (alu_mem_wr),
        .alu_mcycles  (alu_mcycles),
        .nonalu_valid (nonalu_valid),
        .nonalu_byte  (nonalu_byte)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one byte for one cycle
    task automatic put(input logic [7:0] b);
        op_valid = 1'b1;
        op_byte  = b;
        step();
        op_valid = 1'b0;
        op_byte  = 8'h00;
    endtask

    task automatic check_cmd(input string tag, input logic [2:0] op, input logic [2:0] src,
                             input logic [2:0] dest, input logic ext, input logic misc,
                             input logic imm, input logic mrd, input logic mwr,
                             input logic [2:0] mc);
        check({tag, ".valid"},  alu_valid,   1'b1);
        check({tag, ".ready"},  op_ready,    1'b0);
        check({tag, ".op"},     alu_op,      op);
        check({tag, ".src"},    alu_src,     src);
        check({tag, ".dest"},   alu_dest,    dest);
        check({tag, ".ext"},    alu_ext,     ext);
        check({tag, ".misc"},   alu_misc,    misc);
        check({tag, ".imm"},    alu_imm,     imm);
        check({tag, ".mem_rd"}, alu_mem_rd,  mrd);
        check({tag, ".mem_wr"}, alu_mem_wr,  mwr);
        check({tag, ".mcyc"},   alu_mcycles, mc);
        check({tag, ".size"},   alu_size,    1'b0);
    endtask

    // Accept the pending command and confirm it drops
    task automatic drain(input string tag);
        alu_ready = 1'b1;
        step();
        alu_ready = 1'b0;
        check({tag, ".drop_valid"}, alu_valid, 1'b0);
        check({tag, ".drop_ready"}, op_ready,  1'b1);
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        op_valid  = 1'b0;
        op_byte   = 8'h00;
        alu_ready = 1'b0;
        step();
        step();
        check("rst.op_ready",  op_ready,     1'b1);
        check("rst.alu_valid", alu_valid,    1'b0);
        check("rst.nonalu",    nonalu_valid, 1'b0);
        check("rst.op",        alu_op,       3'd0);
        check("rst.mcyc",      alu_mcycles,  3'd0);
        check("rst.imm_data",  alu_imm_data, 8'h00);
        rst_n = 1'b1;
        step();

        // ADD A,C
        check("add.pre_valid", alu_valid, 1'b0);
        put(8'h81);
        check_cmd("add", 3'd0, 3'd1, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
        drain("add");

        // SUB (HL)
        put(8'h96);
        check_cmd("sub_hl", 3'd2, 3'd6, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2);
        drain("sub_hl");

        // BIT 7,(HL)
        put(8'hCB);
        check("bit.mid_valid", alu_valid, 1'b0);
        check("bit.mid_ready", op_ready,  1'b1);
        put(8'h7E);
        check_cmd("bit_hl", 3'd1, 3'd7, 3'd6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd3);
        drain("bit_hl");

        // SWAP A, then SET 0,(HL)
        put(8'hCB);
        put(8'h37);
        check_cmd("swap_a", 3'd6, 3'd7, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
        drain("swap_a");
        put(8'hCB);
        put(8'hC6);
        check_cmd("set_hl", 3'd3, 3'd0, 3'd6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd4);
        drain("set_hl");

        // CP d8 with data byte equal to the prefix value
        put(8'hFE);
        check("cp.mid_valid", alu_valid, 1'b0);
        check("cp.mid_ready", op_ready,  1'b1);
        put(8'hCB);
        check_cmd("cp_d8", 3'd7, 3'd0, 3'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2);
        check("cp_d8.data", alu_imm_data, 8'hCB);
        drain("cp_d8");

        // DAA and CCF
        put(8'h27);
        check_cmd("daa", 3'd0, 3'd7, 3'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1);
        drain("daa");
        put(8'h3F);
        check_cmd("ccf", 3'd3, 3'd7, 3'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1);
        drain("ccf");

        // CPL stalled for 5 cycles while fetch keeps offering a byte
        put(8'h2F);
        op_valid = 1'b1;
        op_byte  = 8'h80;
        for (int i = 0; i < 5; i++) begin
            step();
            check_cmd("cpl_stall", 3'd1, 3'd7, 3'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1);
        end
        op_valid = 1'b0;
        drain("cpl");
        step();
        check("cpl.no_accept", alu_valid, 1'b0);

        // Flush after prefix, then a non-ALU opcode
        put(8'hCB);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush.valid", alu_valid, 1'b0);
        put(8'h06);
        check("ld_b.nonalu", nonalu_valid, 1'b1);
        check("ld_b.byte",   nonalu_byte,  8'h06);
        check("ld_b.valid",  alu_valid,    1'b0);
        step();
        check("ld_b.pulse",  nonalu_valid, 1'b0);
        check("ld_b.valid2", alu_valid,    1'b0);

        // Flush wins over a valid byte
        flush = 1'b1;
        put(8'h81);
        flush = 1'b0;
        check("flush_win.valid", alu_valid, 1'b0);
        check("flush_win.ready", op_ready,  1'b1);

        // Flush in ISSUE drops the command
        put(8'h88);
        check("flush_iss.pre", alu_valid, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_iss.valid", alu_valid, 1'b0);
        check("flush_iss.ready", op_ready,  1'b1);

        // RL (HL), then asynchronous reset while issuing
        put(8'hCB);
        put(8'h16);
        check_cmd("rl_hl", 3'd2, 3'd6, 3'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd4);
        rst_n = 1'b0;
        #1;
        check("arst.valid",  alu_valid,   1'b0);
        check("arst.op",     alu_op,      3'd0);
        check("arst.src",    alu_src,     3'd0);
        check("arst.dest",   alu_dest,    3'd0);
        check("arst.ext",    alu_ext,     1'b0);
        check("arst.mem_rd", alu_mem_rd,  1'b0);
        check("arst.mem_wr", alu_mem_wr,  1'b0);
        check("arst.mcyc",   alu_mcycles, 3'd0);
        step();
        rst_n = 1'b1;
        step();
        check("arst.ready_after", op_ready,  1'b1);
        check("arst.valid_after", alu_valid, 1'b0);
        put(8'h81);
        check_cmd("post_rst", 3'd0, 3'd1, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
        drain("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
